// File: rtl/wbc_irq_src.sv
// Per-channel vectored interrupt request source with ack handshake.
// An arm edge while a request is acknowledged is held in pend and re-requested.
module wbc_irq_src #(
  parameter int          N   = 2,
  parameter logic [15:0] VEC = 16'o000060
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  input  logic          init,
  input  logic [N-1:0]  ready,
  input  logic [N-1:0]  ie,
  input  logic [N-1:0]  iack,
  output logic [N-1:0]  ireq,
  output logic [N*16-1:0] ivec,
  output logic [N-1:0]  pend
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACKD = 2'd2
  } st_e;

  for (genvar g = 0; g < N; g++) begin : g_ch
    localparam logic [15:0] LANE =
      (VEC + 16'(4 * g)) & 16'hfffc;

    st_e  st_q;
    logic arm;
    logic arm_q;
    logic trig;
    logic pnxt;
    logic ireq_q;
    logic pend_q;

    assign arm  = ready[g] & ie[g];
    assign trig = arm & ~arm_q;
    assign pnxt = (pend_q | trig) & ie[g];

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
        st_q   <= IDLE;
        arm_q  <= 1'b0;
        ireq_q <= 1'b0;
        pend_q <= 1'b0;
      end else if (init) begin
        st_q   <= IDLE;
        arm_q  <= 1'b0;
        ireq_q <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        arm_q <= arm;
        unique case (st_q)
          IDLE: begin
            if (trig) begin
              st_q   <= PEND;
              ireq_q <= 1'b1;
            end
          end
          PEND: begin
            // an ack already accepted wins over a late ie drop
            if (iack[g]) begin
              st_q   <= ACKD;
              ireq_q <= 1'b0;
              pend_q <= trig;
            end else if (!ie[g]) begin
              st_q   <= IDLE;
              ireq_q <= 1'b0;
            end
          end
          ACKD: begin
            if (!iack[g]) begin
              pend_q <= 1'b0;
              if (pnxt) begin
                st_q   <= PEND;
                ireq_q <= 1'b1;
              end else begin
                st_q <= IDLE;
              end
            end else begin
              pend_q <= pnxt;
            end
          end
          default: begin
            st_q   <= IDLE;
            ireq_q <= 1'b0;
            pend_q <= 1'b0;
          end
        endcase
      end
    end

    assign ireq[g]            = ireq_q;
    assign pend[g]            = pend_q;
    assign ivec[16*g +: 16]   = LANE;
  end

endmodule

// File: tb/tb_wbc_irq_src.sv
// Bench for wbc_irq_src: directed handshake scenarios plus
// randomized traffic against a behavioural request model.
module tb_wbc_irq_src;

  localparam int N = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            init;
  logic [N-1:0]    ready;
  logic [N-1:0]    ie;
  logic [N-1:0]    iack;
  logic [N-1:0]    ireq;
  logic [N*16-1:0] ivec;
  logic [N-1:0]    pend;

  int checks   = 0;
  int failures = 0;

  // model: per channel, is a request outstanding, is it acked,
  // is a follow-up owed, and the previous arm level
  bit m_req  [N];
  bit m_ack  [N];
  bit m_pend [N];
  bit m_armq [N];

  wbc_irq_src #(.N(N), .VEC(16'o000060)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .init       (init),
    .ready      (ready),
    .ie         (ie),
    .iack       (iack),
    .ireq       (ireq),
    .ivec       (ivec),
    .pend       (pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void m_clear();
    for (int i = 0; i < N; i++) begin
      m_req[i]  = 0;
      m_ack[i]  = 0;
      m_pend[i] = 0;
      m_armq[i] = 0;
    end
  endfunction

  function automatic void m_edge();
    bit arm, rise, owed;
    if (!rst_n || init) begin
      m_clear();
      return;
    end
    for (int i = 0; i < N; i++) begin
      arm  = ready[i] && ie[i];
      rise = arm && !m_armq[i];
      m_armq[i] = arm;
      if (m_req[i]) begin
        if (iack[i]) begin
          m_req[i]  = 0;
          m_ack[i]  = 1;
          m_pend[i] = rise;
        end else if (!ie[i]) begin
          m_req[i] = 0;
        end
      end else if (m_ack[i]) begin
        owed = (m_pend[i] || rise) && ie[i];
        if (iack[i]) begin
          m_pend[i] = owed;
        end else begin
          m_ack[i]  = 0;
          m_pend[i] = 0;
          m_req[i]  = owed;
        end
      end else if (rise) begin
        m_req[i] = 1;
      end
    end
  endfunction

  function automatic logic [N-1:0] m_ireq();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_req[i];
    return v;
  endfunction

  function automatic logic [N-1:0] m_pendv();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
    chk("ireq", 32'(ireq), 32'(m_ireq()));
    chk("pend", 32'(pend), 32'(m_pendv()));
  endtask

  int rq;
  logic prev;

  initial begin
    rst_n = 1'b0;
    init  = 1'b0;
    ready = '0;
    ie    = '0;
    iack  = '0;
    m_clear();
    #12;
    chk("rst_ireq", 32'(ireq), 32'h0);
    chk("rst_pend", 32'(pend), 32'h0);
    rst_n = 1'b1;
    step();

    // vectors and 1-clock request latency
    chk("ivec0", 32'(ivec[15:0]), 32'o60);
    chk("ivec1", 32'(ivec[31:16]), 32'o64);
    ready[0] = 1'b1;
    step();
    chk("arm_wait", 32'(ireq[0]), 32'h0);
    ie[0] = 1'b1;
    step();
    chk("lat1", 32'(ireq[0]), 32'h1);

    // ack pulse, return to idle, no re-request
    iack[0] = 1'b1;
    step();
    chk("ack_drop", 32'(ireq[0]), 32'h0);
    iack[0] = 1'b0;
    step();
    step();
    step();
    chk("no_rereq", 32'(ireq[0]), 32'h0);

    // re-arm while acknowledged -> pend -> second request
    ie[0] = 1'b0;
    step();
    ie[0] = 1'b1;
    step();
    chk("rearm", 32'(ireq[0]), 32'h1);
    iack[0] = 1'b1;
    step();
    ready[0] = 1'b0;
    step();
    ready[0] = 1'b1;
    step();
    chk("pend_set", 32'(pend[0]), 32'h1);
    iack[0] = 1'b0;
    step();
    chk("pend_req", 32'(ireq[0]), 32'h1);
    chk("pend_clr", 32'(pend[0]), 32'h0);
    iack[0] = 1'b1;
    step();
    iack[0] = 1'b0;
    step();
    chk("pend_done", 32'(ireq[0]), 32'h0);

    // ie cancel on channel 1
    ready[1] = 1'b1;
    ie[1]    = 1'b1;
    step();
    chk("ch1_req", 32'(ireq[1]), 32'h1);
    ie[1] = 1'b0;
    step();
    chk("ch1_cancel", 32'(ireq[1]), 32'h0);
    ie[1] = 1'b1;
    step();
    chk("ch1_again", 32'(ireq[1]), 32'h1);

    // init pulse, then async reset between edges
    ie[0] = 1'b0;
    step();
    ie[0] = 1'b1;
    step();
    chk("both_req", 32'(ireq), 32'h3);
    init = 1'b1;
    step();
    chk("init_ireq", 32'(ireq), 32'h0);
    chk("init_pend", 32'(pend), 32'h0);
    init = 1'b0;
    step();
    chk("post_init", 32'(ireq), 32'h3);
    #3;
    rst_n = 1'b0;
    m_clear();
    #1;
    chk("async_ireq", 32'(ireq), 32'h0);
    #1;
    rst_n = 1'b1;
    step();
    chk("rel_trig", 32'(ireq), 32'h3);

    // ready fall keeps request; trigger coincides with iack
    ready[0] = 1'b0;
    step();
    chk("ready_fall", 32'(ireq[0]), 32'h1);
    ready[0] = 1'b1;
    iack[0]  = 1'b1;
    step();
    chk("coin_ackd", 32'(ireq[0]), 32'h0);
    chk("coin_pend", 32'(pend[0]), 32'h1);
    iack[0] = 1'b0;
    rq   = 0;
    prev = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (ireq[0] && !prev) rq++;
      prev = ireq[0];
      iack[0] = ireq[0];
    end
    chk("coin_once", 32'(rq), 32'h1);

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        ready[i] = ($urandom_range(0, 3) != 0);
        ie[i]    = ($urandom_range(0, 7) != 0);
        iack[i]  = ireq[i] ? ($urandom_range(0, 2) == 0)
                           : ($urandom_range(0, 15) == 0);
      end
      init = ($urandom_range(0, 127) == 0);
      step();
    end
    init = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
